// File: rtl/barrier_pkg.sv
// Shared definitions for the 14-lane AND barrier controller: state encoding and default sizes.
// The optional timeout is enabled by defining BARRIER_TIMEOUT_EN.
package barrier_pkg;

    localparam int BARRIER_N  = 14;
    localparam int BARRIER_TW = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FIRE  = 2'd2,
        S_TOUT  = 2'd3
    } state_t;

endpackage

// File: rtl/barrier_and_reduce.sv
// Wide AND reduction deciding barrier completion: every enabled lane must have arrived.
// Kept as its own module so it can be swapped for a library wide-AND macro.
module barrier_and_reduce
    import barrier_pkg::*;
#(
    parameter int W = BARRIER_N
) (
    input  logic [W-1:0] sticky_next,
    input  logic [W-1:0] mask_q,
    output logic         done
);

    logic [W-1:0] lane_ok;

    // A disabled lane always counts as arrived.
    for (genvar gi = 0; gi < W; gi++) begin : g_lane
        assign lane_ok[gi] = sticky_next[gi] | ~mask_q[gi];
    end

    assign done = &lane_ok;

endmodule

// File: rtl/and14_barrier_ctrl.sv
// Barrier controller: sticky masked arrival flags, single-cycle completion pulse.
// Define BARRIER_TIMEOUT_EN to add the TMO port, cycle counter and TOUT abort state.
module and14_barrier_ctrl
    import barrier_pkg::*;
#(
    parameter int N = BARRIER_N
`ifdef BARRIER_TIMEOUT_EN
    ,
    parameter int TW = BARRIER_TW
`endif
) (
    input  logic          CK,
    input  logic          RSTN,
    input  logic          ARM,
    input  logic [N-1:0]  MASK,
    input  logic [N-1:0]  A,
`ifdef BARRIER_TIMEOUT_EN
    input  logic [TW-1:0] TMO,
`endif
    output logic          Z0,
    output logic          TOUT,
    output logic          BUSY,
    output logic [N-1:0]  ARRIVED
);

    state_t       state_q, state_d;
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] sticky_q, sticky_d;
    logic [N-1:0] sticky_next;
    logic         done;

`ifdef BARRIER_TIMEOUT_EN
    logic [TW-1:0] cnt_q, cnt_d;
    logic          tmo_hit;

    // TMO of zero disables the abort at run time.
    assign tmo_hit = (TMO != '0) && (cnt_q == TMO - 1'b1);
`endif

    assign sticky_next = sticky_q | (A & mask_q);

    barrier_and_reduce #(
        .W (N)
    ) u_and_reduce (
        .sticky_next (sticky_next),
        .mask_q      (mask_q),
        .done        (done)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        sticky_d = sticky_q;
`ifdef BARRIER_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ARM) begin
                    mask_d   = MASK;
                    sticky_d = A & MASK;
`ifdef BARRIER_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                    state_d  = S_ARMED;
                end
            end
            S_ARMED: begin
                sticky_d = sticky_next;
                // Completion takes priority over a coincident timeout.
                if (done) begin
                    state_d = S_FIRE;
                end
`ifdef BARRIER_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = S_TOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_FIRE:  state_d = S_IDLE;
            S_TOUT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            sticky_q <= '0;
`ifdef BARRIER_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            sticky_q <= sticky_d;
`ifdef BARRIER_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign Z0      = (state_q == S_FIRE);
    assign BUSY    = (state_q != S_IDLE);
    assign ARRIVED = sticky_q;
`ifdef BARRIER_TIMEOUT_EN
    assign TOUT    = (state_q == S_TOUT);
`else
    assign TOUT    = 1'b0;
`endif

endmodule

// File: tb/tb_and14_barrier_ctrl.sv
// Table-driven bench for and14_barrier_ctrl; each row gives one cycle of inputs and the
// outputs expected after the following rising edge. Timeout rows need BARRIER_TIMEOUT_EN.
module tb_and14_barrier_ctrl;

    typedef struct {
        logic        arm;
        logic [13:0] mask;
        logic [13:0] a;
        logic [7:0]  tmo;
        logic        z0;
        logic        tout;
        logic        busy;
        logic [13:0] arr;
        string       name;
    } vec_t;

    logic        CK;
    logic        RSTN;
    logic        ARM;
    logic [13:0] MASK;
    logic [13:0] A;
`ifdef BARRIER_TIMEOUT_EN
    logic [7:0]  TMO;
`endif
    logic        Z0;
    logic        TOUT;
    logic        BUSY;
    logic [13:0] ARRIVED;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    and14_barrier_ctrl dut (
        .CK      (CK),
        .RSTN    (RSTN),
        .ARM     (ARM),
        .MASK    (MASK),
        .A       (A),
`ifdef BARRIER_TIMEOUT_EN
        .TMO     (TMO),
`endif
        .Z0      (Z0),
        .TOUT    (TOUT),
        .BUSY    (BUSY),
        .ARRIVED (ARRIVED)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    function automatic vec_t mk(input logic arm, input logic [13:0] mask, input logic [13:0] a,
                                input logic [7:0] tmo, input logic z0, input logic tout,
                                input logic busy, input logic [13:0] arr, input string name);
        vec_t v;
        v.arm  = arm;
        v.mask = mask;
        v.a    = a;
        v.tmo  = tmo;
        v.z0   = z0;
        v.tout = tout;
        v.busy = busy;
        v.arr  = arr;
        v.name = name;
        return v;
    endfunction

    task automatic check(input vec_t e);
        checks++;
        if ({Z0, TOUT, BUSY, ARRIVED} !== {e.z0, e.tout, e.busy, e.arr}) begin
            errors++;
            $display("FAIL %s: got z0=%b tout=%b busy=%b arrived=%h, required z0=%b tout=%b busy=%b arrived=%h",
                     e.name, Z0, TOUT, BUSY, ARRIVED, e.z0, e.tout, e.busy, e.arr);
        end else begin
            $display("ok   %s: z0=%b tout=%b busy=%b arrived=%h", e.name, Z0, TOUT, BUSY, ARRIVED);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge CK);
        ARM  = v.arm;
        MASK = v.mask;
        A    = v.a;
`ifdef BARRIER_TIMEOUT_EN
        TMO  = v.tmo;
`endif
        exp_q.push_back(v);
        @(posedge CK);
        #1;
        check(exp_q.pop_front());
    endtask

    initial begin
        logic [13:0] lane;
        logic [13:0] acc;

        // Full barrier, one lane per cycle; mask input wiggles after ARM and must be ignored.
        acc = '0;
        for (int i = 0; i < 14; i++) begin
            lane = 14'd1 << i;
            acc  = acc | lane;
            tbl.push_back(mk(i == 0, (i == 0) ? 14'h3FFF : 14'h0001, lane, 8'd0,
                             i == 13, 1'b0, 1'b1, acc, $sformatf("full_lane%0d", i)));
        end
        tbl.push_back(mk(0, 14'h0, 14'h0, 8'd0, 0, 0, 0, 14'h3FFF, "full_idle"));

        // Partial mask: stray lanes ignored, ARM while busy ignored, ARRIVED held afterwards.
        tbl.push_back(mk(1, 14'h0005, 14'h0000, 8'd0, 0, 0, 1, 14'h0000, "part_arm"));
        tbl.push_back(mk(0, 14'h3FFF, 14'h0002, 8'd0, 0, 0, 1, 14'h0000, "part_l1"));
        tbl.push_back(mk(0, 14'h3FFF, 14'h0008, 8'd0, 0, 0, 1, 14'h0000, "part_l3"));
        tbl.push_back(mk(1, 14'h0000, 14'h0000, 8'd0, 0, 0, 1, 14'h0000, "part_rearm_ign"));
        tbl.push_back(mk(0, 14'h3FFF, 14'h0004, 8'd0, 0, 0, 1, 14'h0004, "part_l2"));
        tbl.push_back(mk(0, 14'h3FFF, 14'h0001, 8'd0, 1, 0, 1, 14'h0005, "part_l0_fire"));
        tbl.push_back(mk(0, 14'h3FFF, 14'h3FFF, 8'd0, 0, 0, 0, 14'h0005, "part_idle"));
        tbl.push_back(mk(0, 14'h3FFF, 14'h3FFF, 8'd0, 0, 0, 0, 14'h0005, "part_hold"));

        // All-zero mask completes two cycles after ARM.
        tbl.push_back(mk(1, 14'h0000, 14'h3FFF, 8'd0, 0, 0, 1, 14'h0000, "m0_arm"));
        tbl.push_back(mk(0, 14'h0000, 14'h0000, 8'd0, 1, 0, 1, 14'h0000, "m0_fire"));
        tbl.push_back(mk(0, 14'h0000, 14'h0000, 8'd0, 0, 0, 0, 14'h0000, "m0_idle"));

        // ARM held high: barrier restarts every 3 cycles.
        for (int i = 0; i < 9; i++) begin
            tbl.push_back(mk(1, 14'h0000, 14'h3FFF, 8'd0, (i % 3) == 1, 1'b0, (i % 3) != 2,
                             14'h0000, $sformatf("armhold_%0d", i)));
        end

        // Last lanes arrive in the ARM cycle itself.
        tbl.push_back(mk(1, 14'h0003, 14'h0003, 8'd0, 0, 0, 1, 14'h0003, "armcyc_arm"));
        tbl.push_back(mk(0, 14'h0003, 14'h0000, 8'd0, 1, 0, 1, 14'h0003, "armcyc_fire"));
        tbl.push_back(mk(0, 14'h0003, 14'h0000, 8'd0, 0, 0, 0, 14'h0003, "armcyc_idle"));

`ifdef BARRIER_TIMEOUT_EN
        // TMO=5: ARMED spans cycles 1..5, TOUT in cycle 6.
        tbl.push_back(mk(1, 14'h0003, 14'h0001, 8'd5, 0, 0, 1, 14'h0001, "tmo_arm"));
        for (int i = 1; i < 5; i++) begin
            tbl.push_back(mk(0, 14'h0003, 14'h0000, 8'd5, 0, 0, 1, 14'h0001,
                             $sformatf("tmo_wait%0d", i)));
        end
        tbl.push_back(mk(0, 14'h0003, 14'h0000, 8'd5, 0, 1, 1, 14'h0001, "tmo_tout"));
        tbl.push_back(mk(0, 14'h0003, 14'h0002, 8'd5, 0, 0, 0, 14'h0001, "tmo_idle"));
        tbl.push_back(mk(0, 14'h0003, 14'h0002, 8'd5, 0, 0, 0, 14'h0001, "tmo_hold"));

        // TMO=3 with completion in the cnt==2 cycle: completion wins.
        tbl.push_back(mk(1, 14'h0003, 14'h0001, 8'd3, 0, 0, 1, 14'h0001, "tie_arm"));
        tbl.push_back(mk(0, 14'h0003, 14'h0000, 8'd3, 0, 0, 1, 14'h0001, "tie_c0"));
        tbl.push_back(mk(0, 14'h0003, 14'h0000, 8'd3, 0, 0, 1, 14'h0001, "tie_c1"));
        tbl.push_back(mk(0, 14'h0003, 14'h0002, 8'd3, 1, 0, 1, 14'h0003, "tie_fire"));
        tbl.push_back(mk(0, 14'h0003, 14'h0000, 8'd3, 0, 0, 0, 14'h0003, "tie_idle"));
`endif

        RSTN = 1'b0;
        ARM  = 1'b0;
        MASK = '0;
        A    = '0;
`ifdef BARRIER_TIMEOUT_EN
        TMO  = '0;
`endif
        repeat (2) @(posedge CK);
        #1;
        check(mk(0, 0, 0, 0, 0, 0, 0, 14'h0000, "reset_state"));
        @(negedge CK);
        RSTN = 1'b1;

        // Reset mid-barrier aborts without any pulse.
        step(mk(1, 14'h3FFF, 14'h1FFF, 8'd0, 0, 0, 1, 14'h1FFF, "rst_arm"));
        step(mk(0, 14'h3FFF, 14'h0000, 8'd0, 0, 0, 1, 14'h1FFF, "rst_armed"));
        @(negedge CK);
        RSTN = 1'b0;
        #1;
        check(mk(0, 0, 0, 0, 0, 0, 0, 14'h0000, "rst_async"));
        @(posedge CK);
        #1;
        check(mk(0, 0, 0, 0, 0, 0, 0, 14'h0000, "rst_held"));
        @(negedge CK);
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 14'h3FFF, 14'h2000, 8'd0, 0, 0, 0, 14'h0000, $sformatf("rst_after%0d", i)));
        end

        foreach (tbl[i]) begin
            step(tbl[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
